multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller_pkg.sv | 54 +++++
 rtl/multicycle_controller_alu_decoder.sv | 34 +++
 rtl/multicycle_controller.sv | 163 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle MIPS controller and its ALU.
// Holds the opcode and funct constants, the FSM state encodings, the ALUOp
// and ALUControl codes, and the mux select codes, so that every block uses
// the same values.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: turns the FSM's ALUOp and the instruction funct field into the
// 3-bit ALU function code.
// Ports:
//   ALUOp      in  2  00 add, 01 sub, 10 decode from Funct
//   Funct      in  6  instruction funct field
//   ALUControl out 3  ALU F input
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [5:0] Funct,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALUCTL_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALUCTL_ADD;
      ALUOP_SUB: ALUControl = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (Funct)
          FUNCT_ADD: ALUControl = ALUCTL_ADD;
          FUNCT_SUB: ALUControl = ALUCTL_SUB;
          FUNCT_AND: ALUControl = ALUCTL_AND;
          FUNCT_OR:  ALUControl = ALUCTL_OR;
          FUNCT_SLT: ALUControl = ALUCTL_SLT;
          default:   ALUControl = ALUCTL_ADD;
        endcase
      end
      default: ALUControl = ALUCTL_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS controller: a Moore FSM that sequences each instruction
// through fetch, decode, execute, memory and writeback, plus the ALU decoder
// and the PC enable logic.
// Ports:
//   clk, reset         in   clock, synchronous active-high reset
//   Op, Funct          in   6 each, opcode and funct field of the instruction register
//   Zero               in   ALU zero flag, for beq
//   IorD .. ALUSrcA    out  1 each, datapath mux selects and write enables
//   ALUSrcB, PCSrc     out  2 each, ALU B operand and next-PC selects
//   ALUControl         out  3, ALU function
//   PCEn               out  PC load enable
//   State              out  4, current state, for debug only
//
// state    | meaning
// ---------+---------------------------------------------
// FETCH    | read instruction, PC <= PC+4
// DECODE   | read registers, compute branch target
// MEMADR   | compute lw/sw address
// MEMRD    | read data memory
// MEMWB    | write loaded word to rt
// MEMWR    | write rt to data memory
// EXECUTE  | R-type ALU operation
// ALUWB    | write ALU result to rd
// BRANCH   | compare for beq, load PC on Zero
// ADDIEX   | add immediate
// ADDIWB   | write addi result to rt
// JUMP     | load jump target into PC
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       PCEn,
  output logic [3:0] State
);

  state_t     state_q;
  state_t     state_d;
  state_t     dec_state;
  logic       irwrite_s;
  logic       memwrite_s;
  logic       regwrite_s;
  logic       pcwrite;
  logic       branch;
  logic [1:0] aluop;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // While reset is held the outputs show FETCH values, whatever the register
  // holds, so the datapath sees a benign cycle before the first real fetch.
  assign dec_state = reset ? S_FETCH : state_q;

  always_comb begin
    IorD       = 1'b0;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    PCSrc      = PCSRC_ALURES;
    aluop      = ALUOP_ADD;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    case (dec_state)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        irwrite_s = 1'b1;
        pcwrite   = 1'b1;
      end
      S_DECODE: ALUSrcB = SRCB_IMMSH;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        regwrite_s = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        regwrite_s = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        aluop   = ALUOP_SUB;
        PCSrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_ADDIWB: regwrite_s = 1'b1;
      S_JUMP: begin
        PCSrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .ALUOp      (aluop),
    .Funct      (Funct),
    .ALUControl (ALUControl)
  );

  assign IRWrite  = irwrite_s & ~reset;
  assign MemWrite = memwrite_s & ~reset;
  assign RegWrite = regwrite_s & ~reset;
  assign PCEn     = (pcwrite | (branch & Zero)) & ~reset;
  assign State    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Op = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Zero = 1'b0;
  logic       IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;
  logic       PCEn;
  logic [3:0] State;

  int checks = 0;
  int failures = 0;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .Zero       (Zero),
    .IorD       (IorD),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .PCSrc      (PCSrc),
    .ALUControl (ALUControl),
    .PCEn       (PCEn),
    .State      (State)
  );

  always #5 clk = ~clk;

  // Model: each instruction is the list of states it visits, chosen by opcode
  // when it leaves FETCH; its length is the instruction latency.
  int mstate = 0;
  int seq[5];
  int len = 2;
  int idx = 0;

  always @(posedge clk) begin
    if (reset) begin
      mstate = 0;
      idx = 0;
    end else if (idx == 0) begin
      case (Op)
        6'b100011: begin seq = '{0, 1, 2, 3, 4};  len = 5; end
        6'b101011: begin seq = '{0, 1, 2, 5, 0};  len = 4; end
        6'b000000: begin seq = '{0, 1, 6, 7, 0};  len = 4; end
        6'b001000: begin seq = '{0, 1, 9, 10, 0}; len = 4; end
        6'b000100: begin seq = '{0, 1, 8, 0, 0};  len = 3; end
        6'b000010: begin seq = '{0, 1, 11, 0, 0}; len = 3; end
        default:   begin seq = '{0, 1, 0, 0, 0};  len = 2; end
      endcase
      idx = 1;
      mstate = seq[1];
    end else begin
      idx = idx + 1;
      if (idx >= len) begin
        idx = 0;
        mstate = 0;
      end else begin
        mstate = seq[idx];
      end
    end
  end

  function automatic logic [2:0] alu_ref(logic [1:0] aop, logic [5:0] fn);
    if (aop == 2'b01) return 3'b110;
    if (aop != 2'b10) return 3'b010;
    if (fn == 6'b100010) return 3'b110;
    if (fn == 6'b100100) return 3'b000;
    if (fn == 6'b100101) return 3'b001;
    if (fn == 6'b101010) return 3'b111;
    return 3'b010;
  endfunction

  // {IorD,IRWrite,MemWrite,RegWrite,RegDst,MemtoReg,ALUSrcA,ALUSrcB,PCSrc,ALUControl,PCEn}
  function automatic logic [14:0] exp_out(int s, logic [5:0] fn, logic z, logic rst);
    logic iord, irw, mw, rw, rd, m2r, sa, pcw, br, pcen;
    logic [1:0] sb, pcs, aop;
    int st;
    iord = 0; irw = 0; mw = 0; rw = 0; rd = 0; m2r = 0; sa = 0; pcw = 0; br = 0;
    sb = 2'b00; pcs = 2'b00; aop = 2'b00;
    st = rst ? 0 : s;
    case (st)
      0:  begin sb = 2'b01; irw = 1; pcw = 1; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  iord = 1;
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mw = 1; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rd = 1; rw = 1; end
      8:  begin sa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin pcs = 2'b10; pcw = 1; end
      default: ;
    endcase
    pcen = pcw | (br & z);
    if (rst) begin irw = 0; mw = 0; rw = 0; pcen = 0; end
    return {iord, irw, mw, rw, rd, m2r, sa, sb, pcs, alu_ref(aop, fn), pcen};
  endfunction

  task automatic lit(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (state %0d)", name, act, exp, State);
    end
  endtask

  // Compares every output against the model, plus an optional literal state.
  task automatic cyc(input int exp_state);
    @(negedge clk);
    lit("model_outputs",
        {1'b0, IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
         ALUSrcB, PCSrc, ALUControl, PCEn},
        {1'b0, exp_out(mstate, Funct, Zero, reset)});
    lit("model_state", {12'd0, State}, 16'(mstate));
    if (exp_state >= 0) lit("literal_state", {12'd0, State}, 16'(exp_state));
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  logic [5:0] fns[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    reset = 1'b1;
    nxt();
    cyc(0);
    lit("rst_pcen", {15'd0, PCEn}, 16'd0);
    lit("rst_irwrite", {15'd0, IRWrite}, 16'd0);
    lit("rst_alusrcb", {14'd0, ALUSrcB}, 16'd1);
    lit("rst_aluctl", {13'd0, ALUControl}, 16'd2);
    nxt();
    reset = 1'b0;

    // lw
    Op = 6'b100011;
    cyc(0);
    lit("fetch_pcen_irwrite", {14'd0, PCEn, IRWrite}, 16'd3);
    nxt(); cyc(1);
    nxt(); cyc(2);
    nxt(); cyc(3);
    lit("lw_iord", {15'd0, IorD}, 16'd1);
    lit("lw_no_regwrite", {15'd0, RegWrite}, 16'd0);
    nxt(); cyc(4);
    lit("lw_wb", {14'd0, RegWrite, MemtoReg}, 16'd3);
    nxt();

    // R-type slt
    Op = 6'b000000; Funct = 6'b101010;
    cyc(0); nxt(); cyc(1); nxt(); cyc(6);
    lit("slt_aluctl", {13'd0, ALUControl}, 16'd7);
    nxt(); cyc(7);
    lit("alu_wb", {14'd0, RegDst, RegWrite}, 16'd3);
    nxt();

    // beq taken / not taken
    Op = 6'b000100; Zero = 1'b1;
    cyc(0); nxt(); cyc(1); nxt(); cyc(8);
    lit("beq_taken", {13'd0, PCSrc, PCEn}, 16'd3);
    nxt();
    Zero = 1'b0;
    cyc(0); nxt(); cyc(1); nxt(); cyc(8);
    lit("beq_not_taken", {15'd0, PCEn}, 16'd0);
    nxt();

    // unknown opcode
    Op = 6'b111111;
    cyc(0); nxt(); cyc(1);
    lit("unknown_no_writes", {12'd0, IRWrite, MemWrite, RegWrite, PCEn}, 16'd0);
    nxt();

    // j
    Op = 6'b000010;
    cyc(0); nxt(); cyc(1); nxt(); cyc(11);
    lit("jump", {13'd0, PCSrc, PCEn}, 16'd5);
    nxt();

    // sw then addi
    Op = 6'b101011;
    cyc(0); nxt(); cyc(1); nxt(); cyc(2);
    lit("sw_adr_no_memwrite", {15'd0, MemWrite}, 16'd0);
    nxt(); cyc(5);
    lit("sw_memwrite", {15'd0, MemWrite}, 16'd1);
    nxt();
    Op = 6'b001000;
    cyc(0); nxt(); cyc(1); nxt(); cyc(9); nxt(); cyc(10);
    lit("addi_wb", {14'd0, RegWrite, RegDst}, 16'd2);
    nxt();

    // reset in MEMRD
    Op = 6'b100011;
    cyc(0); nxt(); cyc(1); nxt(); cyc(2); nxt(); cyc(3);
    reset = 1'b1;
    nxt(); cyc(0);
    lit("rst_midinstr_enables", {13'd0, PCEn, MemWrite, RegWrite}, 16'd0);
    nxt();
    reset = 1'b0;
    cyc(0);
    lit("post_rst_fetch", {14'd0, PCEn, IRWrite}, 16'd3);
    nxt();

    // randomized
    for (int i = 0; i < 3000; i++) begin
      if (mstate == 0) begin
        if ($urandom_range(0, 6) == 6) Op = 6'($urandom);
        else Op = ops[$urandom_range(0, 5)];
      end
      if ($urandom_range(0, 5) == 5) Funct = 6'($urandom);
      else Funct = fns[$urandom_range(0, 4)];
      Zero = 1'($urandom);
      reset = ($urandom_range(0, 39) == 0);
      cyc(-1);
      nxt();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
